pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised next-generation program-counter unit for the RISC-V core's fetch stage. It holds the architectural fetch PC and selects the next PC from sequential increment, branch, jump, trap, or return redirects, honouring a pipeline stall. An optional return-address stack (RAS) predicts `ret` targets. `pc_out` addresses instruction memory; `pc_plus` feeds the link-register writeback path.

## Interface
Parameters:
- `PC_W`, 8: PC width in bits; all PC arithmetic is modulo 2^PC_W.
- `INC`, 4: sequential increment; power of two, less than 2^PC_W.
- `RESET_VEC`, 0: PC value loaded on reset.
- `TRAP_VEC`, 8'hF0: trap handler address; must be INC-aligned.
- `RAS_DEPTH`, 4: RAS entries; power of two, at least 2. Used only when RAS_EN is defined.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold the PC and RAS this cycle; trap overrides it.
- `trap`  in  1  redirect to TRAP_VEC.
- `br_taken`  in  1  redirect to `br_target`.
- `br_target`  in  PC_W  branch target.
- `jmp_valid`  in  1  redirect to `jmp_target`.
- `jmp_target`  in  PC_W  jump target.
- `jmp_call`  in  1  qualifies `jmp_valid`: push a return address onto the RAS.
- `ret_valid`  in  1  return: redirect to the RAS top and pop it.
- `pc_out`  out  PC_W  current fetch PC.
- `pc_plus`  out  PC_W  combinational `pc_out + INC`, wraps modulo 2^PC_W.
- `ras_empty`  out  1  RAS holds 0 entries.
- `ras_full`  out  1  RAS holds RAS_DEPTH entries.
- `ret_miss`  out  1  one-cycle registered pulse: a return was accepted while the RAS was empty.

## Operation
- Targets are forced to alignment: the low log2(INC) bits of `br_target` and `jmp_target` are cleared before loading.
- Next-PC priority (highest first):
  1. `trap`: TRAP_VEC. Stall is ignored. The RAS is unchanged.
  2. `stall`: hold the PC. No push and no pop.
  3. `br_taken`: `br_target`. `jmp_call` and `ret_valid` are ignored.
  4. `jmp_valid`: `jmp_target`. If `jmp_call` is set, push `pc_plus`. `ret_valid` is ignored.
  5. `ret_valid`: the RAS top, then pop.
  6. Otherwise: `pc_plus`.
- RAS is a circular buffer with a top pointer and a count (0..RAS_DEPTH).
  - Push when full: overwrite the oldest entry. The count stays at RAS_DEPTH.
  - Pop when empty: next PC is `pc_plus`, `ret_miss` pulses, and the count stays 0.
- A `jmp_valid` with `jmp_call` never pops, even if `ret_valid` is also high.
- Counter arithmetic never leaves the range 0..RAS_DEPTH. The pointer wraps modulo RAS_DEPTH.

## Timing
- Reset values (asynchronous, asserted immediately):
  - `pc_out` = RESET_VEC, so `pc_plus` = RESET_VEC+INC.
  - RAS count = 0, `ras_empty` = 1, `ras_full` = 0, `ret_miss` = 0.
  - RAS entry contents are don't-care.
- Reset mid-operation discards all pending redirects and stack contents. The first edge after deassertion applies normal next-PC selection.
- Redirect latency is 1 cycle: inputs sampled at edge N appear on `pc_out` after edge N.
- `ras_empty` and `ras_full` are decoded from the registered count and change the cycle after a push or pop.
- `ret_miss` is high for exactly the one cycle following the accepted empty pop.
- Wrap-around: PC = 2^PC_W−INC with no redirect goes to 0.

## Configuration
- `PC_UNIT_RAS_EN` defined: RAS built as described above.
- `PC_UNIT_RAS_EN` undefined:
  - No RAS storage is built.
  - `ret_valid` and `jmp_call` are ignored; a cycle with only `ret_valid` advances to `pc_plus`.
  - `ras_empty` is tied to 1, `ras_full` to 0, `ret_miss` to 0.
- All ports are present in both builds.

## Test plan
- Reset and sequence: assert `rst` mid-cycle → `pc_out` = 0x00 immediately. Release, 4 idle cycles → 0x04, 0x08, 0x0C, 0x10. From PC 0xFC, one idle edge → 0x00.
- Priority: at PC 0x10, assert `trap`, `stall`, `br_taken` (0x40) and `jmp_valid` (0x80) together → 0xF0. Next, `stall` + `br_taken` → PC holds 0xF0. Next, `br_taken` (0x41) + `jmp_valid` → 0x40 (alignment applied).
- Call/return: at 0x20, jump-and-link to 0x60 → pc 0x60, `ras_empty` = 0 next cycle. Then `ret_valid` → pc 0x24, `ras_empty` = 1.
- Overflow: 5 nested calls with RAS_DEPTH = 4 → `ras_full` = 1. Then 4 returns → the 4 newest return addresses in reverse order. A 5th return → `pc_plus`, with `ret_miss` high for one cycle.
- Stall and mixed events: `stall` with `jmp_call` → no push and PC holds. A call jump with `ret_valid` at count 2 → count 3 and no pop.
- RAS disabled build: call then `ret_valid` at 0x60 → 0x64, `ret_miss` stays 0, `ras_empty` stays 1.

Source files
------------

// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential/branch/jump/trap/return next-PC select; optional RAS under PC_UNIT_RAS_EN.
// Latency: redirects visible on pc_out one cycle after the sampling edge; pc_plus is combinational.
// Backpressure: stall holds PC and RAS (trap overrides stall); no ready/valid handshake.
module pc_unit #(
    parameter int              PC_W      = 8,
    parameter int              INC       = 4,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'('hF0),
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            trap,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp_valid,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            jmp_call,
    input  logic            ret_valid,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] pc_plus,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ret_miss
);

    localparam logic [PC_W-1:0] INC_V      = PC_W'(INC);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~(INC_V - PC_W'(1));

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] br_aligned;
    logic [PC_W-1:0] jmp_aligned;

    assign pc_out      = pc_q;
    assign pc_plus     = pc_q + INC_V;
    assign br_aligned  = br_target & ALIGN_MASK;
    assign jmp_aligned = jmp_target & ALIGN_MASK;

`ifdef PC_UNIT_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_q;
    logic [PTR_W-1:0] top_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [PC_W-1:0]  ras_top;
    logic             push;
    logic             pop;
    logic             miss;
    logic             ret_miss_q;

    assign ras_top   = ras_mem[top_q];
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_FULL);
    assign ret_miss  = ret_miss_q;
`else
    logic unused_ras_cfg;

    assign unused_ras_cfg = ^{jmp_call, ret_valid, (RAS_DEPTH == 0)};
    assign ras_empty      = 1'b1;
    assign ras_full       = 1'b0;
    assign ret_miss       = 1'b0;
`endif

    always_comb begin
        pc_d = pc_plus;
`ifdef PC_UNIT_RAS_EN
        push = 1'b0;
        pop  = 1'b0;
        miss = 1'b0;
`endif
        if (trap) begin
            pc_d = TRAP_VEC;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (br_taken) begin
            pc_d = br_aligned;
        end else if (jmp_valid) begin
            pc_d = jmp_aligned;
`ifdef PC_UNIT_RAS_EN
            push = jmp_call;
`endif
        end
`ifdef PC_UNIT_RAS_EN
        else if (ret_valid) begin
            // An empty stack falls through to sequential fetch and flags the miss.
            if (cnt_q != '0) begin
                pc_d = ras_top;
                pop  = 1'b1;
            end else begin
                miss = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef PC_UNIT_RAS_EN
    // A push at full count advances the pointer onto the oldest slot, overwriting it.
    always_comb begin
        top_d = top_q;
        cnt_d = cnt_q;
        if (push) begin
            top_d = top_q + PTR_W'(1);
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop) begin
            top_d = top_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q      <= '0;
            cnt_q      <= '0;
            ret_miss_q <= 1'b0;
        end else begin
            top_q      <= top_d;
            cnt_q      <= cnt_d;
            ret_miss_q <= miss;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[top_d] <= pc_plus;
        end
    end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with default parameters; RAS checks follow the PC_UNIT_RAS_EN build choice.
module tb_pc_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic       trap;
    logic       br_taken;
    logic [7:0] br_target;
    logic       jmp_valid;
    logic [7:0] jmp_target;
    logic       jmp_call;
    logic       ret_valid;
    logic [7:0] pc_out;
    logic [7:0] pc_plus;
    logic       ras_empty;
    logic       ras_full;
    logic       ret_miss;

    int n_checks = 0;
    int n_pass   = 0;

    pc_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .trap       (trap),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .jmp_call   (jmp_call),
        .ret_valid  (ret_valid),
        .pc_out     (pc_out),
        .pc_plus    (pc_plus),
        .ras_empty  (ras_empty),
        .ras_full   (ras_full),
        .ret_miss   (ret_miss)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        stall = 0; trap = 0; br_taken = 0; br_target = 0;
        jmp_valid = 0; jmp_target = 0; jmp_call = 0; ret_valid = 0;
    endtask

    // Advance one edge and settle just after it; inputs set before the call are sampled.
    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic call(input logic [7:0] tgt);
        jmp_valid = 1; jmp_call = 1; jmp_target = tgt;
        step();
    endtask

    task automatic ret();
        ret_valid = 1;
        step();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1;
        #12 rst = 0;                       // edges at 15, 25 -> 0x08
        #18 rst = 1;                       // t=30: mid-cycle assertion
        #1;
        chk("rst_pc", pc_out, 8'h00);
        chk("rst_pc_plus", pc_plus, 8'h04);
        chk("rst_empty", ras_empty, 1);
        chk("rst_full", ras_full, 0);
        chk("rst_miss", ret_miss, 0);
        #1 rst = 0;

        step(); chk("seq1", pc_out, 8'h04);
        step(); chk("seq2", pc_out, 8'h08);
        step(); chk("seq3", pc_out, 8'h0C);
        step(); chk("seq4", pc_out, 8'h10);

        trap = 1; stall = 1; br_taken = 1; br_target = 8'h40; jmp_valid = 1; jmp_target = 8'h80;
        step(); chk("prio_trap", pc_out, 8'hF0);
        stall = 1; br_taken = 1; br_target = 8'h40;
        step(); chk("prio_stall", pc_out, 8'hF0);
        br_taken = 1; br_target = 8'h41; jmp_valid = 1; jmp_target = 8'h80;
        step(); chk("prio_br_align", pc_out, 8'h40);
        jmp_valid = 1; jmp_target = 8'h83;
        step(); chk("jmp_align", pc_out, 8'h80);

        jmp_valid = 1; jmp_target = 8'hFC;
        step(); chk("pre_wrap", pc_out, 8'hFC);
        chk("wrap_pc_plus", pc_plus, 8'h00);
        step(); chk("wrap", pc_out, 8'h00);

        jmp_valid = 1; jmp_target = 8'h20;
        step(); chk("to_20", pc_out, 8'h20);
        call(8'h60); chk("call_pc", pc_out, 8'h60);
`ifdef PC_UNIT_RAS_EN
        chk("call_nonempty", ras_empty, 0);
        ret(); chk("ret_pc", pc_out, 8'h24);
        chk("ret_empty", ras_empty, 1);
        chk("ret_nomiss", ret_miss, 0);

        call(8'h30); call(8'h40); call(8'h50); call(8'h70);
        chk("four_full", ras_full, 1);
        call(8'h90); chk("five_pc", pc_out, 8'h90);
        chk("five_full", ras_full, 1);
        ret(); chk("pop1", pc_out, 8'h74);
        chk("pop1_notfull", ras_full, 0);
        ret(); chk("pop2", pc_out, 8'h54);
        ret(); chk("pop3", pc_out, 8'h44);
        ret(); chk("pop4", pc_out, 8'h34);
        chk("pop4_empty", ras_empty, 1);
        ret(); chk("miss_pc", pc_out, 8'h38);
        chk("miss_pulse", ret_miss, 1);
        step(); chk("miss_clear_pc", pc_out, 8'h3C);
        chk("miss_clear", ret_miss, 0);

        stall = 1; jmp_valid = 1; jmp_call = 1; jmp_target = 8'hA0;
        step(); chk("stall_call_pc", pc_out, 8'h3C);
        chk("stall_call_empty", ras_empty, 1);
        call(8'hA0); call(8'hB0);
        ret_valid = 1; call(8'hC0); chk("call_ret_pc", pc_out, 8'hC0);
        ret(); chk("cr_pop1", pc_out, 8'hB4);
        ret(); chk("cr_pop2", pc_out, 8'hA4);
        ret(); chk("cr_pop3", pc_out, 8'h40);
        chk("cr_empty", ras_empty, 1);
        br_taken = 1; br_target = 8'h10; ret_valid = 1; jmp_call = 1;
        step(); chk("br_over_ret", pc_out, 8'h10);
        chk("br_no_push", ras_empty, 1);

        call(8'h60);
        #3 rst = 1;
        #1 chk("midrst_empty", ras_empty, 1);
`else
        chk("call_empty_off", ras_empty, 1);
        ret(); chk("ret_off_pc", pc_out, 8'h64);
        chk("ret_off_miss", ret_miss, 0);
        chk("ret_off_empty", ras_empty, 1);
        chk("ret_off_full", ras_full, 0);
        stall = 1; ret_valid = 1;
        step(); chk("ret_off_stall", pc_out, 8'h64);
        ret(); chk("ret_off_miss2_pc", pc_out, 8'h68);
        chk("ret_off_miss2", ret_miss, 0);
        #3 rst = 1;
        #1;
`endif
        chk("midrst_pc", pc_out, 8'h00);
        #1 rst = 0;
        step(); chk("post_rst", pc_out, 8'h04);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
